// File: rtl/dmem_responder_if.sv
// Load/store port between the CPU data side (master) and the data-memory responder (slave).
// One request handshake and one response handshake, each valid/ready.
interface dmem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts a word request, waits WAIT_CYCLES,
// commits the read or byte-masked write on entry to RESP, and holds the response until taken.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus,
  output logic [15:0]      rd_count,
  output logic [15:0]      wr_count
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam int         NWORDS    = 1 << DEPTH_LOG2;

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic                  accept;
  logic                  commit;

  logic                  we_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [3:0]            be_p0;

  logic                  c_we;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [3:0]            c_be;
  logic                  c_err;
  logic [DEPTH_LOG2-1:0] c_idx;

  logic [DATA_WIDTH-1:0] mem [NWORDS];

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != '0);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] byte_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                       input logic [DATA_WIDTH-1:0] new_w,
                                                       input logic [3:0]            be);
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign accept        = (state == ST_IDLE) && bus.req_valid;

  // With no wait states the commit happens on the accept edge, so it must see the live request.
  always_comb begin
    c_we    = we_p0;
    c_addr  = addr_p0;
    c_wdata = wdata_p0;
    c_be    = be_p0;
    commit  = (state == ST_WAIT) && (wait_cnt == 4'd0);
    if (WAIT_CYCLES == 0 && accept) begin
      c_we    = bus.req_we;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
      c_be    = bus.req_be;
      commit  = 1'b1;
    end
  end

  assign c_err = addr_err(c_addr);
  assign c_idx = c_addr[DEPTH_LOG2+1:2];

  // Stage p0: request capture and array write (data path, not reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
      be_p0    <= bus.req_be;
    end
    if (rst_n && commit && c_we && !c_err)
      mem[c_idx] <= byte_merge(mem[c_idx], c_wdata, c_be);
  end

  // Stage p1: control FSM, response registers and completion counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= 4'd0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      rd_count      <= 16'd0;
      wr_count      <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state <= ST_IDLE;
            if (we_p0) wr_count <= wr_count + 16'd1;
            else       rd_count <= rd_count + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (commit) begin
        bus.rsp_err   <= c_err;
        bus.rsp_rdata <= (!c_we && !c_err) ? mem[c_idx] : '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;
  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic [15:0] rd2, wr2, rd0, wr0;
  int          checks, errors;

  dmem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();
  dmem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .rd_count(rd2), .wr_count(wr2));
  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .rd_count(rd0), .wr_count(wr0));

  assign bus2.req_valid = req_valid & ~sel;
  assign bus0.req_valid = req_valid & sel;
  assign bus2.req_we    = req_we;
  assign bus0.req_we    = req_we;
  assign bus2.req_addr  = req_addr;
  assign bus0.req_addr  = req_addr;
  assign bus2.req_wdata = req_wdata;
  assign bus0.req_wdata = req_wdata;
  assign bus2.req_be    = req_be;
  assign bus0.req_be    = req_be;
  assign bus2.rsp_ready = rsp_ready;
  assign bus0.rsp_ready = rsp_ready;

  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;
  logic [15:0] m_rd, m_wr;
  assign m_req_ready = sel ? bus0.req_ready : bus2.req_ready;
  assign m_rsp_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
  assign m_rsp_err   = sel ? bus0.rsp_err   : bus2.rsp_err;
  assign m_rsp_rdata = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
  assign m_rd        = sel ? rd0 : rd2;
  assign m_wr        = sel ? wr0 : wr2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full transaction with rsp_ready high; lat counts edges from the accept edge to rsp_valid.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
    int n;
    n = 0;
    while (!m_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!m_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rdata = m_rsp_rdata;
    err   = m_rsp_err;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        stable;
  int          n;

  initial begin
    checks = 0; errors = 0;
    sel = 1'b0; rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
    req_addr = '0; req_wdata = '0; req_be = '0;
    #12;
    check("rst_req_ready", {31'd0, m_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("rst_rsp_rdata", m_rsp_rdata, 32'd0);
    check("rst_rsp_err",   {31'd0, m_rsp_err}, 32'd0);
    check("rst_counts",    {m_rd, m_wr}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_req_ready", {31'd0, m_req_ready}, 32'd1);
    check("idle_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("idle_counts",    {m_rd, m_wr}, 32'd0);

    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("wr10_err", {31'd0, er}, 32'd0);
    check("wr10_lat", lat, 32'd3);
    check("wr10_rdata", rd, 32'd0);
    check("wr10_wrcnt", {16'd0, m_wr}, 32'd1);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("rd10_data", rd, 32'hDEADBEEF);
    check("rd10_err", {31'd0, er}, 32'd0);
    check("rd10_lat", lat, 32'd3);
    check("rd10_counts", {m_rd, m_wr}, {16'd1, 16'd1});

    do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    do_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, er, lat);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("partial_data", rd, 32'h11BB33DD);

    do_txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
    do_txn(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    check("misalign_err", {31'd0, er}, 32'd1);
    check("misalign_rdata", rd, 32'd0);
    do_txn(1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, lat);
    check("range_err", {31'd0, er}, 32'd1);
    do_txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check("word0_kept", rd, 32'hCAFEF00D);
    check("word0_err", {31'd0, er}, 32'd0);
    check("err_counts", {m_rd, m_wr}, {16'd4, 16'd5});

    // Backpressure: response held while a second request waits.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_addr = 32'h20;
    n = 0;
    while (!m_rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(m_rsp_valid && m_rsp_rdata == 32'hDEADBEEF && !m_req_ready)) stable = 1'b0;
      @(posedge clk); #1;
    end
    check("bp_stable", {31'd0, stable}, 32'd1);
    check("bp_rdcnt_held", {16'd0, m_rd}, 32'd4);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", {31'd0, m_req_ready}, 32'd1);
    check("bp_rdcnt", {16'd0, m_rd}, 32'd5);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_accepted", {31'd0, m_req_ready}, 32'd0);
    lat = 1;
    while (!m_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp_second_lat", lat, 32'd3);
    check("bp_second_data", m_rsp_rdata, 32'h11BB33DD);
    @(posedge clk); #1;

    // Reset in the middle of a write's wait states.
    do_txn(1'b1, 32'h30, 32'h0, 4'hF, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, m_req_ready}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_counts", {m_rd, m_wr}, 32'd0);
    do_txn(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    check("midrst_data", rd, 32'd0);
    check("midrst_rdcnt", {m_rd, m_wr}, {16'd1, 16'd0});

    // Zero wait states.
    sel = 1'b1;
    #1;
    check("w0_counts_rst", {m_rd, m_wr}, 32'd0);
    do_txn(1'b1, 32'h44, 32'h01020304, 4'hF, rd, er, lat);
    check("w0_wr_lat", lat, 32'd1);
    do_txn(1'b0, 32'h44, 32'h0, 4'h0, rd, er, lat);
    check("w0_rd_lat", lat, 32'd1);
    check("w0_rd_data", rd, 32'h01020304);
    do_txn(1'b0, 32'h2001, 32'h0, 4'h0, rd, er, lat);
    check("w0_err", {31'd0, er}, 32'd1);
    check("w0_counts", {m_rd, m_wr}, {16'd2, 16'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
